risc_v_32_i_mc: RTL and testbench

Parametrised multi-cycle RV32I/RV32E core: the next generation of the single-cycle core top. Decode, ALU, register file and a sequencing FSM sit in one block. One shared instruction/data bus with a valid/ready handshake, so the core tolerates wait-state memory. It exposes retire/debug observability and a halt state for illegal, misaligned and system instructions.

---
 rtl/rv_mc_pkg.sv | 68 ++++++
 rtl/rv_regfile.sv | 30 +++
 rtl/risc_v_32_i_mc.sv | 219 +++++++++++++++++++++
 tb/tb_risc_v_32_i_mc.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mc_pkg.sv
// Shared encodings and small helpers for the multi-cycle RV32I/RV32E core.
package rv_mc_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_t;

  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_MEM, ST_HALT} state_t;

  typedef enum logic [1:0] {HC_NONE, HC_ILLEGAL, HC_MISALIGN, HC_SYSTEM} halt_cause_t;

  // alt selects SUB (for OP funct3 0) or SRA (funct3 5)
  function automatic alu_op_t alu_sel(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_SLL:   return a << b[4:0];
      ALU_SLT:   return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:  return {31'b0, a < b};
      ALU_XOR:   return a ^ b;
      ALU_SRL:   return a >> b[4:0];
      ALU_SRA:   return $unsigned($signed(a) >>> b[4:0]);
      ALU_OR:    return a | b;
      ALU_AND:   return a & b;
      default:   return b;
    endcase
  endfunction

endpackage

// File: rtl/rv_regfile.sv
// GPR file: two async read ports, one sync write port, x0 hardwired to zero.
module rv_regfile #(
  parameter  int NUM_REGS = 32,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [AW-1:0] ra1_i,
  input  logic [AW-1:0] ra2_i,
  output logic [31:0]   rd1_o,
  output logic [31:0]   rd2_o,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [31:0]   wd_i
);

  logic [31:0] regs_q [NUM_REGS];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i && wa_i != '0) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd1_o = (ra1_i == '0) ? '0 : regs_q[ra1_i];
  assign rd2_o = (ra2_i == '0) ? '0 : regs_q[ra2_i];

endmodule

// File: rtl/risc_v_32_i_mc.sv
// Multi-cycle RV32I/RV32E core on a single valid/ready bus: FETCH -> EXEC -> (MEM) -> FETCH.
module risc_v_32_i_mc
  import rv_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        retire,
  output logic [31:0] retire_pc,
  output logic [31:0] value_from_alu,
  output logic        halted,
  output logic [1:0]  halt_cause
);

  localparam int         AW = $clog2(NUM_REGS);
  localparam logic [5:0] NR = 6'(NUM_REGS);

  state_t      state_q, state_d;
  halt_cause_t hc_q, hc_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, ea_q, ea_d, sdata_q, sdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d, req_en_q;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_v, rs2_v, op_a, op_b, alu_res, target, pc4, ld_sh, ld_val;
  logic        illegal, bad_reg, is_sys, is_ld, is_st, use_rd, use_rs1, use_rs2;
  logic        taken, is_jump, mis_ls, rf_we;
  logic [31:0] rf_wd;
  logic [3:0]  ls_be;
  logic [31:0] ls_data;
  alu_op_t     aop;

  assign opc = ir_q[6:0];
  assign rd  = ir_q[11:7];
  assign f3  = ir_q[14:12];
  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];
  assign f7  = ir_q[31:25];

  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u = {ir_q[31:12], 12'b0};
  assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  assign pc4   = pc_q + 32'd4;

  rv_regfile #(.NUM_REGS(NUM_REGS)) u_rf (
    .clk_i (clk),
    .rst_ni(reset),
    .ra1_i (rs1[AW-1:0]),
    .ra2_i (rs2[AW-1:0]),
    .rd1_o (rs1_v),
    .rd2_o (rs2_v),
    .we_i  (rf_we),
    .wa_i  (rd[AW-1:0]),
    .wd_i  (rf_wd)
  );

  always_comb begin
    illegal = 1'b0; is_sys = 1'b0; is_ld = 1'b0; is_st = 1'b0;
    use_rd = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0;
    aop = ALU_ADD; op_a = rs1_v; op_b = imm_i;
    case (opc)
      OP_LUI:    begin use_rd = 1'b1; aop = ALU_PASSB; op_b = imm_u; end
      OP_AUIPC:  begin use_rd = 1'b1; op_a = pc_q; op_b = imm_u; end
      OP_JAL:    use_rd = 1'b1;
      OP_JALR:   begin use_rd = 1'b1; use_rs1 = 1'b1; illegal = (f3 != 3'd0); end
      OP_BRANCH: begin use_rs1 = 1'b1; use_rs2 = 1'b1; op_b = rs2_v; illegal = (f3 == 3'd2 || f3 == 3'd3); end
      OP_LOAD:   begin is_ld = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1;
                       illegal = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7); end
      OP_STORE:  begin is_st = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; op_b = imm_s; illegal = (f3 > 3'd2); end
      OP_IMM:    begin use_rd = 1'b1; use_rs1 = 1'b1;
                       aop = alu_sel(f3, (f3 == 3'd5) && f7[5]);
                       illegal = (f3 == 3'd1 && f7 != 7'd0) || (f3 == 3'd5 && (f7 & 7'b1011111) != 7'd0); end
      OP_OP:     begin use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; op_b = rs2_v;
                       aop = alu_sel(f3, f7[5]);
                       illegal = (f7 != 7'd0) && !(f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)); end
      OP_FENCE:  ;
      // only ECALL/EBREAK are recognised; CSR forms are treated as illegal
      OP_SYSTEM: begin is_sys = (ir_q[31:21] == 11'd0) && (ir_q[19:7] == 13'd0); illegal = !is_sys; end
      default:   illegal = 1'b1;
    endcase
    bad_reg = (use_rd && {1'b0, rd} >= NR) || (use_rs1 && {1'b0, rs1} >= NR) ||
              (use_rs2 && {1'b0, rs2} >= NR);
  end

  assign alu_res = alu(aop, op_a, op_b);

  always_comb begin
    case (f3)
      F3_BEQ:  taken = (rs1_v == rs2_v);
      F3_BNE:  taken = (rs1_v != rs2_v);
      F3_BLT:  taken = ($signed(rs1_v) <  $signed(rs2_v));
      F3_BGE:  taken = ($signed(rs1_v) >= $signed(rs2_v));
      F3_BLTU: taken = (rs1_v <  rs2_v);
      F3_BGEU: taken = (rs1_v >= rs2_v);
      default: taken = 1'b0;
    endcase
    case (opc)
      OP_JAL:  target = pc_q + imm_j;
      OP_JALR: target = (rs1_v + imm_i) & ~32'd1;
      default: target = pc_q + imm_b;
    endcase
    is_jump = (opc == OP_JAL) || (opc == OP_JALR) || (opc == OP_BRANCH && taken);
    mis_ls  = (f3[1:0] == 2'd1 && alu_res[0]) || (f3[1:0] == 2'd2 && alu_res[1:0] != 2'd0);
    case (f3[1:0])
      2'd0:    begin ls_be = 4'b0001 << alu_res[1:0]; ls_data = {4{rs2_v[7:0]}}; end
      2'd1:    begin ls_be = alu_res[1] ? 4'hC : 4'h3; ls_data = {2{rs2_v[15:0]}}; end
      default: begin ls_be = 4'hF; ls_data = rs2_v; end
    endcase
  end

  always_comb begin
    ld_sh = mem_rdata >> {ea_q[1:0], 3'b000};
    case (f3)
      F3_B:    ld_val = {{24{ld_sh[7]}}, ld_sh[7:0]};
      F3_H:    ld_val = {{16{ld_sh[15]}}, ld_sh[15:0]};
      F3_BU:   ld_val = {24'd0, ld_sh[7:0]};
      F3_HU:   ld_val = {16'd0, ld_sh[15:0]};
      default: ld_val = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q; pc_d = pc_q; ir_d = ir_q; ea_d = ea_q; sdata_d = sdata_q;
    be_d = be_q; we_d = we_q; hc_d = hc_q;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = pc_q; mem_be = 4'hF; mem_wdata = '0;
    retire = 1'b0; rf_we = 1'b0; rf_wd = alu_res; value_from_alu = '0;
    case (state_q)
      // req_en_q keeps the bus quiet for the cycle right after reset
      ST_FETCH: begin
        mem_req = req_en_q;
        if (req_en_q && mem_ready) begin
          ir_d    = mem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        value_from_alu = alu_res;
        if (illegal || bad_reg) begin
          hc_d = HC_ILLEGAL; state_d = ST_HALT;
        end else if (is_sys) begin
          hc_d = HC_SYSTEM; state_d = ST_HALT;
        end else if (is_ld || is_st) begin
          if (mis_ls) begin
            hc_d = HC_MISALIGN; state_d = ST_HALT;
          end else begin
            ea_d = alu_res; sdata_d = ls_data; be_d = ls_be; we_d = is_st;
            state_d = ST_MEM;
          end
        end else if (is_jump && target[1]) begin
          hc_d = HC_MISALIGN; state_d = ST_HALT;
        end else begin
          rf_we   = use_rd;
          rf_wd   = (opc == OP_JAL || opc == OP_JALR) ? pc4 : alu_res;
          pc_d    = is_jump ? target : pc4;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = {ea_q[31:2], 2'b00};
        mem_be    = be_q;
        mem_wdata = sdata_q;
        if (mem_ready) begin
          rf_we   = !we_q;
          rf_wd   = ld_val;
          pc_d    = pc4;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      ea_q     <= '0;
      sdata_q  <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      hc_q     <= HC_NONE;
      req_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      ea_q     <= ea_d;
      sdata_q  <= sdata_d;
      be_q     <= be_d;
      we_q     <= we_d;
      hc_q     <= hc_d;
      req_en_q <= 1'b1;
    end
  end

  assign retire_pc  = pc_q;
  assign halted     = (state_q == ST_HALT);
  assign halt_cause = hc_q;

endmodule

// File: tb/tb_risc_v_32_i_mc.sv
// Directed bench: RV32I core (dut0, reset pc 0) and RV32E core (dut1, reset pc 0x40) on wait-state memories.
module tb_risc_v_32_i_mc;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        req [2], we [2], ready [2], retire [2], halted [2];
  logic [31:0] addr [2], wdata [2], rdata [2], rpc [2], alu_v [2];
  logic [3:0]  be [2];
  logic [1:0]  hc [2];

  int          waits [2];
  logic        stall [2];
  logic        tb_we [2];
  logic [5:0]  tb_a [2];
  logic [31:0] tb_d [2];

  int tests = 0;
  int fails = 0;

  risc_v_32_i_mc #(.RESET_PC(32'h0), .NUM_REGS(32)) dut0 (
    .clk(clk), .reset(rst_n[0]), .mem_req(req[0]), .mem_we(we[0]), .mem_addr(addr[0]),
    .mem_wdata(wdata[0]), .mem_be(be[0]), .mem_rdata(rdata[0]), .mem_ready(ready[0]),
    .retire(retire[0]), .retire_pc(rpc[0]), .value_from_alu(alu_v[0]),
    .halted(halted[0]), .halt_cause(hc[0]));

  risc_v_32_i_mc #(.RESET_PC(32'h40), .NUM_REGS(16)) dut1 (
    .clk(clk), .reset(rst_n[1]), .mem_req(req[1]), .mem_we(we[1]), .mem_addr(addr[1]),
    .mem_wdata(wdata[1]), .mem_be(be[1]), .mem_rdata(rdata[1]), .mem_ready(ready[1]),
    .retire(retire[1]), .retire_pc(rpc[1]), .value_from_alu(alu_v[1]),
    .halted(halted[1]), .halt_cause(hc[1]));

  // Memory: code below 0x80 answers at once, data at/above 0x80 inserts waits[g] wait states
  for (genvar g = 0; g < 2; g++) begin : g_mem
    logic [31:0] mem [64];
    int          cnt;
    assign ready[g] = req[g] && !stall[g] && ((addr[g] < 32'h80) || (cnt >= waits[g]));
    assign rdata[g] = mem[addr[g][7:2]];
    always @(posedge clk) begin
      if (!req[g] || ready[g]) cnt <= 0;
      else cnt <= cnt + 1;
      if (tb_we[g]) mem[tb_a[g]] <= tb_d[g];
      else if (req[g] && ready[g] && we[g])
        for (int b = 0; b < 4; b++)
          if (be[g][b]) mem[addr[g][7:2]][8*b +: 8] <= wdata[g][8*b +: 8];
    end
  end

  int          cyc = 0;
  logic [31:0] rpcs [$];
  int          rcyc [$];
  logic [31:0] ralu [$];
  int          nstore = 0;
  int          nret1 = 0;
  logic [3:0]  sbe;
  logic [31:0] swd;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (retire[0]) begin
      rpcs.push_back(rpc[0]);
      rcyc.push_back(cyc);
      ralu.push_back(alu_v[0]);
    end
    if (req[0] && we[0] && ready[0]) begin
      nstore <= nstore + 1;
      sbe    <= be[0];
      swd    <= wdata[0];
    end
    if (retire[1]) nret1 <= nret1 + 1;
  end

  task automatic poke(input int d, input logic [31:0] a, input logic [31:0] data);
    tb_we[d] = 1'b1; tb_a[d] = a[7:2]; tb_d[d] = data;
    @(negedge clk);
    tb_we[d] = 1'b0;
  endtask

  task automatic wait_halt(input int d, input int lim, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < lim && !ok) begin
      @(negedge clk);
      ok = halted[d];
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n[0] = 1'b0;
    @(negedge clk);
    poke(0, 32'h00, 32'h0050_0093);  // addi x1,x0,5
    poke(0, 32'h04, 32'hFF90_8113);  // addi x2,x1,-7
    poke(0, 32'h08, 32'h0820_2023);  // sw   x2,0x80(x0)
    poke(0, 32'h0C, 32'h0800_0183);  // lb   x3,0x80(x0)
    poke(0, 32'h10, 32'h0830_4203);  // lbu  x4,0x83(x0)
    poke(0, 32'h14, 32'h0011_4663);  // blt  x2,x1,+12
    poke(0, 32'h18, 32'h0000_0000);
    poke(0, 32'h1C, 32'h0000_0000);
    poke(0, 32'h20, 32'h0011_6663);  // bltu x2,x1,+12
    poke(0, 32'h24, 32'h0020_2283);  // lw   x5,2(x0)
    poke(0, 32'h80, 32'h0000_0000);
    tests++; if (req[0] !== 1'b0) begin fails++; $display("FAIL reset_req got=%b exp=0", req[0]); end
    tests++; if (retire[0] !== 1'b0) begin fails++; $display("FAIL reset_retire got=%b exp=0", retire[0]); end
    tests++; if (halted[0] !== 1'b0 || hc[0] !== 2'd0) begin fails++;
      $display("FAIL reset_halt got=%b/%0d exp=0/0", halted[0], hc[0]); end
    tests++; if (alu_v[0] !== 32'h0) begin fails++; $display("FAIL reset_alu got=%h exp=0", alu_v[0]); end
    tests++; if (dut0.pc_q !== 32'h0) begin fails++; $display("FAIL reset_pc got=%h exp=0", dut0.pc_q); end
    tests++; if (dut0.u_rf.regs_q[1] !== 32'h0) begin fails++;
      $display("FAIL reset_x1 got=%h exp=0", dut0.u_rf.regs_q[1]); end
  endtask

  task automatic test_program();
    logic [31:0] exp_pc [7] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h20};
    int          exp_dt [6] = '{2, 5, 5, 5, 2, 2};
    int          base = rpcs.size();
    bit          ok;
    int          nreq = 0;
    waits[0] = 2;
    rst_n[0] = 1'b1;
    wait_halt(0, 200, ok);
    tests++; if (!ok) begin fails++; $display("FAIL prog_halt_timeout got=running exp=halted"); end
    tests++; if (hc[0] !== 2'd2) begin fails++; $display("FAIL prog_cause got=%0d exp=2", hc[0]); end
    tests++; if (rpcs.size() - base != 7) begin fails++;
      $display("FAIL prog_retire_count got=%0d exp=7", rpcs.size() - base); end
    if (rpcs.size() - base == 7) begin
      for (int i = 0; i < 7; i++) begin
        tests++; if (rpcs[base+i] !== exp_pc[i]) begin fails++;
          $display("FAIL prog_retire_pc[%0d] got=%h exp=%h", i, rpcs[base+i], exp_pc[i]); end
      end
      for (int i = 0; i < 6; i++) begin
        tests++; if (rcyc[base+i+1] - rcyc[base+i] != exp_dt[i]) begin fails++;
          $display("FAIL prog_latency[%0d] got=%0d exp=%0d", i, rcyc[base+i+1] - rcyc[base+i], exp_dt[i]); end
      end
      tests++; if (ralu[base] !== 32'h5 || ralu[base+1] !== 32'hFFFF_FFFE) begin fails++;
        $display("FAIL prog_alu got=%h,%h exp=5,fffffffe", ralu[base], ralu[base+1]); end
    end
    tests++; if (dut0.u_rf.regs_q[2] !== 32'hFFFF_FFFE) begin fails++;
      $display("FAIL prog_x2 got=%h exp=fffffffe", dut0.u_rf.regs_q[2]); end
    tests++; if (dut0.u_rf.regs_q[3] !== 32'hFFFF_FFFE) begin fails++;
      $display("FAIL prog_lb_x3 got=%h exp=fffffffe", dut0.u_rf.regs_q[3]); end
    tests++; if (dut0.u_rf.regs_q[4] !== 32'h0000_00FF) begin fails++;
      $display("FAIL prog_lbu_x4 got=%h exp=000000ff", dut0.u_rf.regs_q[4]); end
    tests++; if (dut0.u_rf.regs_q[5] !== 32'h0) begin fails++;
      $display("FAIL prog_lw_x5 got=%h exp=0", dut0.u_rf.regs_q[5]); end
    tests++; if (nstore != 1 || sbe !== 4'hF || swd !== 32'hFFFF_FFFE) begin fails++;
      $display("FAIL prog_store got=n%0d be=%h d=%h exp=n1 be=f d=fffffffe", nstore, sbe, swd); end
    repeat (5) begin @(negedge clk); if (req[0]) nreq++; end
    tests++; if (nreq != 0 || !halted[0]) begin fails++;
      $display("FAIL prog_halt_quiet got=req%0d halted%b exp=req0 halted1", nreq, halted[0]); end
  endtask

  task automatic test_alu_jump();
    int base;
    bit ok;
    rst_n[0] = 1'b0;
    waits[0] = 0;
    @(negedge clk);
    poke(0, 32'h00, 32'h8000_0337);  // lui  x6,0x80000
    poke(0, 32'h04, 32'h4043_5393);  // srai x7,x6,4
    poke(0, 32'h08, 32'h0080_046F);  // jal  x8,+8
    poke(0, 32'h0C, 32'h0000_0000);  // illegal if the jump falls through
    poke(0, 32'h10, 32'h0010_0073);  // ebreak
    base = rpcs.size();
    rst_n[0] = 1'b1;
    wait_halt(0, 100, ok);
    tests++; if (!ok || hc[0] !== 2'd3) begin fails++;
      $display("FAIL alu_ebreak got=halt%b cause%0d exp=halt1 cause3", ok, hc[0]); end
    tests++; if (rpcs.size() - base != 3) begin fails++;
      $display("FAIL alu_retire_count got=%0d exp=3", rpcs.size() - base); end
    tests++; if (dut0.u_rf.regs_q[6] !== 32'h8000_0000) begin fails++;
      $display("FAIL alu_lui got=%h exp=80000000", dut0.u_rf.regs_q[6]); end
    tests++; if (dut0.u_rf.regs_q[7] !== 32'hF800_0000) begin fails++;
      $display("FAIL alu_srai got=%h exp=f8000000", dut0.u_rf.regs_q[7]); end
    tests++; if (dut0.u_rf.regs_q[8] !== 32'h0000_000C) begin fails++;
      $display("FAIL alu_jal_link got=%h exp=0000000c", dut0.u_rf.regs_q[8]); end
  endtask

  task automatic test_fetch_stall();
    int base;
    int n = 0;
    rst_n[0] = 1'b0;
    stall[0] = 1'b1;
    @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      tests++; if (req[0] !== 1'b1 || addr[0] !== 32'h0) begin fails++;
        $display("FAIL stall_hold got=req%b addr%h exp=req1 addr0", req[0], addr[0]); end
    end
    rst_n[0] = 1'b0;
    @(negedge clk);
    tests++; if (req[0] !== 1'b0) begin fails++; $display("FAIL stall_reset_drop got=%b exp=0", req[0]); end
    stall[0] = 1'b0;
    rst_n[0] = 1'b1;
    base = rpcs.size();
    @(negedge clk);
    tests++; if (req[0] !== 1'b1 || addr[0] !== 32'h0) begin fails++;
      $display("FAIL stall_restart got=req%b addr%h exp=req1 addr0", req[0], addr[0]); end
    while (rpcs.size() == base && n < 20) begin @(negedge clk); n++; end
    tests++; if (rpcs.size() == base || rpcs[base] !== 32'h0) begin fails++;
      $display("FAIL stall_first_retire got=%0d exp=pc0 retired", rpcs.size() - base); end
  endtask

  task automatic test_rv32e();
    bit ok;
    rst_n[1] = 1'b0;
    @(negedge clk);
    poke(1, 32'h40, 32'h0010_0893);  // addi x17,x0,1
    rst_n[1] = 1'b1;
    wait_halt(1, 50, ok);
    tests++; if (!ok || hc[1] !== 2'd1) begin fails++;
      $display("FAIL e_bad_reg got=halt%b cause%0d exp=halt1 cause1", ok, hc[1]); end
    tests++; if (nret1 != 0) begin fails++; $display("FAIL e_no_retire got=%0d exp=0", nret1); end
    rst_n[1] = 1'b0;
    @(negedge clk);
    tests++; if (halted[1] !== 1'b0 || hc[1] !== 2'd0 || req[1] !== 1'b0) begin fails++;
      $display("FAIL e_reset got=h%b c%0d r%b exp=h0 c0 r0", halted[1], hc[1], req[1]); end
    rst_n[1] = 1'b1;
    @(negedge clk);
    tests++; if (req[1] !== 1'b1 || addr[1] !== 32'h40) begin fails++;
      $display("FAIL e_refetch got=req%b addr%h exp=req1 addr40", req[1], addr[1]); end
    rst_n[1] = 1'b0;
    @(negedge clk);
    poke(1, 32'h40, 32'h0000_0073);  // ecall
    rst_n[1] = 1'b1;
    wait_halt(1, 50, ok);
    tests++; if (!ok || hc[1] !== 2'd3) begin fails++;
      $display("FAIL e_ecall got=halt%b cause%0d exp=halt1 cause3", ok, hc[1]); end
  endtask

  initial begin
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    waits[0] = 0; waits[1] = 0;
    stall[0] = 1'b0; stall[1] = 1'b0;
    tb_we[0] = 1'b0; tb_we[1] = 1'b0;
    tb_a[0] = '0; tb_a[1] = '0; tb_d[0] = '0; tb_d[1] = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_program();
    test_alu_jump();
    test_fetch_stall();
    test_rv32e();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
